// File: rtl/sha256_pkg.sv
// Shared SHA-256 scheduler definitions: state enum, small sigma functions and,
// when SHA256_SCHED_WK_EN is defined, the 64-entry round-constant table.
package sha256_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

    localparam int WORD_W     = 32;
    localparam int WINDOW_LEN = 16;
    localparam int ROUNDS     = 64;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SHA256_SCHED_WK_EN
    localparam logic [31:0] K_TABLE [ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

endpackage

// File: rtl/sha256_sched_sigma.sv
// Combinational next-window-word generator: sum = sigma1(a) + b + sigma0(c) + d (mod 2^32).
module sha256_sched_sigma
    import sha256_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    output logic [31:0] sum
);

    assign sum = sigma1(a) + b + sigma0(c) + d;

endmodule

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message-schedule expander: 16-word sliding window, one W_t per handshake.
// Define SHA256_SCHED_WK_EN to present W_t + K_t on w_word instead of raw W_t.
module sha256_msg_scheduler
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         block_valid,
    output logic         block_ready,
    input  logic [511:0] block_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [5:0]   w_round,
    output logic [31:0]  w_word,
    output logic         w_last
);

    sched_state_t state_reg, state_next;
    logic [5:0]   round_reg, round_next;
    logic [31:0]  window_reg  [WINDOW_LEN];
    logic [31:0]  window_next [WINDOW_LEN];
    logic [31:0]  new_word;
    logic         load;
    logic         advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            round_reg <= round_next;
        end
    end

    // block_valid is only looked at in IDLE, so a block offered during RUN is ignored.
    always_comb begin
        state_next = state_reg;
        round_next = round_reg;
        load       = 1'b0;
        advance    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (block_valid) begin
                    load       = 1'b1;
                    state_next = RUN;
                    round_next = '0;
                end
            end
            RUN: begin
                if (w_ready) begin
                    advance    = 1'b1;
                    round_next = round_reg + 6'd1;
                    if (round_reg == 6'd63) begin
                        state_next = IDLE;
                        round_next = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    sha256_sched_sigma u_sigma (
        .a   (window_reg[14]),
        .b   (window_reg[9]),
        .c   (window_reg[1]),
        .d   (window_reg[0]),
        .sum (new_word)
    );

    // Word gi of the block sits at [511-32*gi -: 32] (big-endian word order).
    generate
        for (genvar gi = 0; gi < WINDOW_LEN; gi++) begin : g_window
            logic [31:0] shift_in;
            if (gi < WINDOW_LEN - 1) begin : g_mid
                assign shift_in = window_reg[gi+1];
            end else begin : g_top
                assign shift_in = new_word;
            end

            assign window_next[gi] = load    ? block_data[511-32*gi -: 32] :
                                     advance ? shift_in : window_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    window_reg[gi] <= '0;
                end else begin
                    window_reg[gi] <= window_next[gi];
                end
            end
        end
    endgenerate

    assign block_ready = (state_reg == IDLE);
    assign w_valid     = (state_reg == RUN);
    assign w_round     = round_reg;
    assign w_last      = (state_reg == RUN) && (round_reg == 6'd63);

`ifdef SHA256_SCHED_WK_EN
    // Gated to RUN so the idle/reset value of w_word stays at the raw window word.
    assign w_word = (state_reg == RUN) ? (window_reg[0] + K_TABLE[round_reg]) : window_reg[0];
`else
    assign w_word = window_reg[0];
`endif

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Directed bench for sha256_msg_scheduler; honours SHA256_SCHED_WK_EN when defined.
module tb_sha256_msg_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         block_valid = 1'b0;
    logic         block_ready;
    logic [511:0] block_data = '0;
    logic         w_valid;
    logic         w_ready = 1'b1;
    logic [5:0]   w_round;
    logic [31:0]  w_word;
    logic         w_last;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_q[$];

    logic [31:0] exp_w [64];
    int          hand_n;
    int          hand_t [8];
    logic [31:0] hand_v [8];

    localparam logic [511:0] ABC_BLK  = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] ONES_BLK = {512{1'b1}};

`ifdef SHA256_SCHED_WK_EN
    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
`endif

    sha256_msg_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .block_valid (block_valid),
        .block_ready (block_ready),
        .block_data  (block_data),
        .w_valid     (w_valid),
        .w_ready     (w_ready),
        .w_round     (w_round),
        .w_word      (w_word),
        .w_last      (w_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && block_valid && block_ready) acc_q.push_back(cyc);
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook 64-entry schedule expansion of a block.
    task automatic build_exp(input logic [511:0] blk);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = ss1(w[i-2]) + w[i-7] + ss0(w[i-15]) + w[i-16];
        for (int i = 0; i < 64; i++) begin
`ifdef SHA256_SCHED_WK_EN
            exp_w[i] = w[i] + K_TB[i];
`else
            exp_w[i] = w[i];
`endif
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " block_ready"}, 32'(block_ready), 32'd1);
        check({tag, " w_valid"}, 32'(w_valid), 32'd0);
        check({tag, " w_last"}, 32'(w_last), 32'd0);
    endtask

    task automatic send_block(input logic [511:0] blk, input bit hold);
        check("accept block_ready", 32'(block_ready), 32'd1);
        block_valid = 1'b1;
        block_data  = blk;
        @(posedge clk); #1;
        if (!hold) block_valid = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: foreign block pulsed at t=10;
    // 3: asynchronous reset asserted at t=20.
    task automatic consume(input int mode, input string name);
        int t = 0;
        int guard = 0;
        bit rdy;
        while (t < 64) begin
            rdy = (mode == 1) ? ((guard % 4 == 0) || (guard % 4 == 3)) : 1'b1;
            w_ready = rdy;
            check($sformatf("%s t%0d w_valid", name, t), 32'(w_valid), 32'd1);
            check($sformatf("%s t%0d w_round", name, t), 32'(w_round), 32'(t));
            check($sformatf("%s t%0d w_word", name, t), w_word, exp_w[t]);
            check($sformatf("%s t%0d w_last", name, t), 32'(w_last), 32'(t == 63));
            check($sformatf("%s t%0d block_ready", name, t), 32'(block_ready), 32'd0);
            for (int h = 0; h < hand_n; h++)
                if (hand_t[h] == t) check($sformatf("%s hand W%0d", name, t), w_word, hand_v[h]);
            if (mode == 2) begin
                block_valid = (t == 10);
                block_data  = ONES_BLK;
            end
            if (mode == 3 && t == 20) begin
                #2 rst_n = 1'b0;
                #1;
                check_idle({name, " async rst"});
                check({name, " async rst w_round"}, 32'(w_round), 32'd0);
                check({name, " async rst w_word"}, w_word, 32'd0);
                @(posedge clk); #1;
                check_idle({name, " held rst"});
                rst_n = 1'b1;
                $display("%s: reset at t=20, outputs returned to reset values", name);
                return;
            end
            @(posedge clk); #1;
            if (rdy) t++;
            guard++;
            if (guard > 400) begin
                check({name, " cycle budget"}, 32'(guard), 32'd400);
                return;
            end
        end
        w_ready = 1'b1;
        block_valid = 1'b0;
        $display("%s: 64 words consumed in %0d cycles", name, guard);
    endtask

    task automatic set_hand_abc();
`ifdef SHA256_SCHED_WK_EN
        hand_n = 1;
        hand_t[0] = 0;  hand_v[0] = 32'hA3EC9318;
`else
        hand_n = 5;
        hand_t[0] = 0;  hand_v[0] = 32'h61626380;
        hand_t[1] = 15; hand_v[1] = 32'h00000018;
        hand_t[2] = 16; hand_v[2] = 32'h61626380;
        hand_t[3] = 17; hand_v[3] = 32'h000F0000;
        hand_t[4] = 63; hand_v[4] = 32'h12B1EDEB;
`endif
    endtask

    initial begin
        // Reset state
        #12;
        check_idle("reset");
        check("reset w_round", 32'(w_round), 32'd0);
        check("reset w_word", w_word, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "abc" block, ready held high
        build_exp(ABC_BLK);
        set_hand_abc();
        send_block(ABC_BLK, 1'b0);
        consume(0, "abc");
        check_idle("abc after last");

        // All-ones block
        build_exp(ONES_BLK);
`ifdef SHA256_SCHED_WK_EN
        hand_n = 0;
`else
        hand_n = 3;
        hand_t[0] = 0;  hand_v[0] = 32'hFFFFFFFF;
        hand_t[1] = 15; hand_v[1] = 32'hFFFFFFFF;
        hand_t[2] = 16; hand_v[2] = 32'h203FFFFC;
`endif
        send_block(ONES_BLK, 1'b0);
        consume(0, "ones");
        check_idle("ones after last");

        // "abc" with ready toggling 1,0,0,1
        build_exp(ABC_BLK);
        set_hand_abc();
        send_block(ABC_BLK, 1'b0);
        consume(1, "abc_stall");
        check_idle("abc_stall after last");

        // Foreign block offered mid-run must be ignored
        send_block(ABC_BLK, 1'b0);
        consume(2, "abc_ignore");
        check_idle("abc_ignore after last");

        // Reset at round 20, then a fresh block
        send_block(ABC_BLK, 1'b0);
        consume(3, "abc_rst");
        @(posedge clk); #1;
        send_block(ABC_BLK, 1'b0);
        consume(0, "abc_post_rst");
        check_idle("abc_post_rst after last");

        // Two blocks back to back with block_valid held high
        acc_q.delete();
        send_block(ABC_BLK, 1'b1);
        consume(0, "b2b_first");
        block_valid = 1'b1;
        check("b2b bubble block_ready", 32'(block_ready), 32'd1);
        @(posedge clk); #1;
        block_valid = 1'b0;
        consume(0, "b2b_second");
        check("b2b accept count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() == 2)
            check("b2b spacing", 32'(acc_q[1] - acc_q[0]), 32'd65);
        $display("b2b: accepts recorded %0d", acc_q.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_scheduler.md
# sha256_msg_scheduler

Message-schedule expander for the SHA-256 core. It accepts one padded 512-bit block and produces the 64 schedule words W0..W63 in round order, one per handshake. This is the producer of the per-round `wordIn` consumed by the round Generator. It runs a 16-word sliding window, so no 64-entry storage is required.

## Interface
- No parameters; widths are fixed by SHA-256.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `block_valid` input 1: `block_data` is valid.
- `block_ready` output 1: scheduler can accept a block.
- `block_data` input 512: padded block; word 0 = `[511:480]`, word 15 = `[31:0]` (big-endian).
- `w_valid` output 1: `w_word` is valid.
- `w_ready` input 1: consumer accepts `w_word` this cycle.
- `w_round` output 6: round index t of `w_word`.
- `w_word` output 32: W_t, or W_t+K_t when `SHA256_SCHED_WK_EN` is defined.
- `w_last` output 1: high with `w_valid` when t = 63.
- Reset: one clock; asynchronous, active-low (`rst_n`).

## Operation
- States are IDLE and RUN.
  - IDLE: `block_ready`=1, `w_valid`=0.
  - RUN: `block_ready`=0, `w_valid`=1.
- IDLE→RUN on `block_valid && block_ready`:
  - window[0..15] ← words 0..15.
  - round counter ← 0.
- RUN advance on `w_valid && w_ready`:
  - new = σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32.
  - window shifts down one position and window[15] ← new.
  - round counter +1.
- RUN→IDLE on the accepted handshake at round 63. The counter does not wrap within a block.
- σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- All additions are 32-bit, carries discarded.
- `w_word` = window[0]; `w_round` = counter; `w_last` = (state==RUN && counter==63).
- `block_valid` during RUN is ignored; the block must be held by the producer until `block_ready`.
- `w_ready` low in RUN: all state frozen, outputs stable.
- Reset mid-block: immediate return to IDLE; the partial block is discarded and no words are emitted.

## Timing
- Reset values:
  - `block_ready`=1 (IDLE), `w_valid`=0, `w_round`=0, `w_word`=0, `w_last`=0.
  - Window and counter are cleared.
- Latency: block accepted at edge k → W0 presented in the cycle after edge k.
- With `w_ready` held high, W_t is presented in cycle k+1+t and `w_last` in cycle k+64.
- `block_ready` rises the cycle after the round-63 handshake. There is one bubble between blocks, so throughput is 65 cycles per block.
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.

## Configuration
- `SHA256_SCHED_WK_EN` defined: `w_word` = (window[0] + K[counter]) mod 2^32, pre-adding the round constant for the Generator.
  - The pre-add is combinational from registered state and introduces no extra latency.
  - Window contents are unchanged; only the output is affected.
- `SHA256_SCHED_WK_EN` undefined: `w_word` = raw W_t, and no K table is instantiated.

## Structure
- Shared package `sha256_pkg` holds:
  - the 64×32 K constant table;
  - the σ0/σ1 functions;
  - the state enum (IDLE, RUN).
- One sub-module, `sha256_sched_sigma`, is combinational and computes new window word = σ1(a)+b+σ0(c)+d. It may use the team's 32-bit carry-save compressor followed by a final adder.

## Test plan
- "abc" block (0x61626380, 14×0, 0x00000018) with `w_ready`=1:
  - W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB.
  - `w_last` only at t=63; `block_ready`=1 the next cycle.
- All-ones block → W0..W15=0xFFFFFFFF, W16=0x203FFFFC.
- "abc" block with `w_ready` toggling 1,0,0,1 → `w_word`/`w_round` held stable while low; same 64 values in order; no duplicates or skips.
- `block_valid` pulsed with a different block during RUN → ignored; current sequence unchanged; `block_ready` stays 0.
- Reset asserted at round 20 → outputs return to reset values asynchronously. A new block after release starts at W0 with `w_round`=0.
- With `SHA256_SCHED_WK_EN`, "abc" block → t=0 `w_word`=0xA3EC9318 (0x61626380+0x428A2F98). Repeat the two-block back-to-back run and check 65-cycle spacing.
